alu_acc_seq: RTL and testbench

- Parametrised accumulator ALU with registered AC, registered flags, and a start/busy/done handshake.
- Single-cycle ops: load, add/sub, logic. Multi-cycle ops: iterative shifts and shift-add multiply.
- Sits between the instruction register (opcode, immediate) and the memory data register (MDR). Its AC output drives the display and datapath.

---
 rtl/alu_acc_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_acc_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_seq.sv
// Accumulator ALU: single-cycle load/arith/logic ops plus iterative shifts and a
// shift-add multiply, with a start/busy/done handshake and registered flags.
module alu_acc_seq #(
    parameter int W   = 8,
    parameter int OPW = 5,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic [W-1:0]   value,
    input  logic [W-1:0]   mdr,
    output logic [W-1:0]   ac,
    output logic           zflg,
    output logic           nflg,
    output logic           cflg,
    output logic           vflg,
    output logic           busy,
    output logic           done
);
    localparam int CW = $clog2(W + 1);

    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_LDM  = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(6);
    localparam logic [OPW-1:0] OP_AND  = OPW'(7);
    localparam logic [OPW-1:0] OP_OR   = OPW'(8);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(9);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(10);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_SAR  = OPW'(12);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(13);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {K_SHL, K_SAR, K_MUL} kind_t;

    // Result packing for both helpers: {overflow, carry/borrow, sum[W-1:0]}
    function automatic logic [W+1:0] add_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s};
    endfunction

    function automatic logic [W+1:0] sub_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} - {1'b0, b};
        return {(a[W-1] != b[W-1]) && (s[W-1] != a[W-1]), s};
    endfunction

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d;
    logic [W-1:0]    ac_q, ac_d;
    logic            zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, vf_q, vf_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic            sc_q, sc_d;

    logic            wr;
    logic [W-1:0]    res;
    logic            res_c, res_v;
    logic [W+1:0]    arith;
    logic [W:0]      msum;
    logic [SHW-1:0]  n;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        ac_d    = ac_q;
        zf_d    = zf_q;
        nf_d    = nf_q;
        cf_d    = cf_q;
        vf_d    = vf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        sc_d    = sc_q;
        wr      = 1'b0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        arith   = '0;
        msum    = '0;
        n       = value[SHW-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    wr = 1'b1;
                    case (opcode)
                        OP_LDI:  res = value;
                        OP_LDM:  res = mdr;
                        OP_ADD:  arith = add_op(ac_q, mdr);
                        OP_SUB:  arith = sub_op(ac_q, mdr);
                        OP_ADDI: arith = add_op(ac_q, value);
                        OP_SUBI: arith = sub_op(ac_q, value);
                        OP_AND:  res = ac_q & mdr;
                        OP_OR:   res = ac_q | mdr;
                        OP_XOR:  res = ac_q ^ mdr;
                        OP_NOT:  res = ~ac_q;
                        OP_SHL, OP_SAR: begin
                            // A zero-count shift completes at once and leaves AC as is
                            res = ac_q;
                            if (n != '0) begin
                                wr      = 1'b0;
                                kind_d  = (opcode == OP_SHL) ? K_SHL : K_SAR;
                                prod_d  = {{W{1'b0}}, ac_q};
                                cnt_d   = CW'(n);
                                sc_d    = 1'b0;
                                state_d = RUN;
                                busy_d  = 1'b1;
                            end
                        end
                        OP_MUL: begin
                            wr      = 1'b0;
                            kind_d  = K_MUL;
                            prod_d  = {{W{1'b0}}, mdr};
                            mcand_d = ac_q;
                            cnt_d   = CW'(W);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        default: begin
                            wr     = 1'b0;
                            done_d = 1'b1;
                        end
                    endcase
                    if (opcode == OP_ADD || opcode == OP_SUB ||
                        opcode == OP_ADDI || opcode == OP_SUBI) begin
                        res   = arith[W-1:0];
                        res_c = arith[W];
                        res_v = arith[W+1];
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                case (kind_q)
                    K_SHL: begin
                        prod_d[W-1:0] = {prod_q[W-2:0], 1'b0};
                        sc_d          = prod_q[W-1];
                    end
                    K_SAR: begin
                        prod_d[W-1:0] = {prod_q[W-1], prod_q[W-1:1]};
                        sc_d          = prod_q[0];
                    end
                    default: begin
                        // Add multiplicand into the upper half, then shift the whole product right
                        msum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
                        prod_d = {msum, prod_q[W-1:1]};
                    end
                endcase
                if (cnt_q == CW'(1)) begin
                    wr      = 1'b1;
                    res     = prod_d[W-1:0];
                    res_c   = (kind_q == K_MUL) ? (prod_d[2*W-1:W] != '0) : sc_d;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            ac_d   = res;
            zf_d   = (res == '0);
            nf_d   = res[W-1];
            cf_d   = res_c;
            vf_d   = res_v;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= K_SHL;
            ac_q    <= '0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            cf_q    <= 1'b0;
            vf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            sc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            ac_q    <= ac_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            cf_q    <= cf_d;
            vf_q    <= vf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            sc_q    <= sc_d;
        end
    end

    assign ac   = ac_q;
    assign zflg = zf_q;
    assign nflg = nf_q;
    assign cflg = cf_q;
    assign vflg = vf_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed-vector bench for alu_acc_seq (W=8, OPW=5) with hand-computed results.
module tb_alu_acc_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] opcode;
    logic [7:0] value;
    logic [7:0] mdr;
    logic [7:0] ac;
    logic       zflg, nflg, cflg, vflg, busy, done;

    int nvec = 0;
    int nerr = 0;
    int lat, bcnt;
    bit overlap;

    alu_acc_seq #(.W(8), .OPW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .value(value),
        .mdr(mdr), .ac(ac), .zflg(zflg), .nflg(nflg), .cflg(cflg), .vflg(vflg),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle issue: afterwards we sit in cycle k+1
    task automatic issue(input logic [4:0] op, input logic [7:0] val, input logic [7:0] m);
        start = 1'b1; opcode = op; value = val; mdr = m;
        step();
        start = 1'b0;
    endtask

    // Issue and wait for done; optional mdr toggling and a stray start at busy cycle inj
    task automatic run_op(input logic [4:0] op, input logic [7:0] val, input logic [7:0] m,
                          input bit tog, input int inj, output int l, output int b);
        issue(op, val, m);
        l = 1; b = 0;
        while (!done && l < 40) begin
            if (busy) b++;
            if (busy && done) overlap = 1'b1;
            if (tog) mdr = ~mdr;
            if (l == inj) begin
                start = 1'b1; opcode = 5'd1; value = 8'h55;
            end else begin
                start = 1'b0;
            end
            step();
            l++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        overlap = 1'b0;
        reset = 1'b1; start = 1'b0; opcode = '0; value = '0; mdr = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_ac", {24'd0, ac}, 32'h00);
        chk("rst_flags", {28'd0, zflg, nflg, cflg, vflg}, 32'h0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'h0);

        // LDI 0x7F then ADD 1: signed overflow into 0x80
        issue(5'd1, 8'h7F, 8'h00);
        chk("ldi_done", {30'd0, busy, done}, 32'b01);
        chk("ldi_ac", {24'd0, ac}, 32'h7F);
        issue(5'd3, 8'h00, 8'h01);
        chk("add_done", {30'd0, busy, done}, 32'b01);
        chk("add_ac", {24'd0, ac}, 32'h80);
        chk("add_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0101);
        // ADDI 0x80 to 0x80: carry out, overflow, zero
        issue(5'd5, 8'h80, 8'h00);
        chk("addi_ac", {24'd0, ac}, 32'h00);
        chk("addi_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b1011);
        step();
        chk("done_drop", {30'd0, busy, done}, 32'b00);

        // LDI 5, SUB 5 -> 0; SUBI 1 -> 0xFF with borrow
        issue(5'd1, 8'h05, 8'h00);
        issue(5'd4, 8'h00, 8'h05);
        chk("sub_ac", {24'd0, ac}, 32'h00);
        chk("sub_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b1000);
        issue(5'd6, 8'h01, 8'h00);
        chk("subi_ac", {24'd0, ac}, 32'hFF);
        chk("subi_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0110);
        issue(5'd0, 8'h12, 8'h34);
        chk("nop_ac", {24'd0, ac}, 32'hFF);
        chk("nop_flags", {28'd0, zflg, nflg, cflg, vflg}, 32'b0110);
        chk("nop_done", {30'd0, busy, done}, 32'b01);

        // Logic ops: 0xF0 AND 0x3C, OR 0x0F, XOR 0xFF, NOT
        issue(5'd1, 8'hF0, 8'h00);
        issue(5'd7, 8'h00, 8'h3C);
        chk("and_ac", {24'd0, ac}, 32'h30);
        issue(5'd8, 8'h00, 8'h0F);
        chk("or_ac", {24'd0, ac}, 32'h3F);
        issue(5'd9, 8'h00, 8'hFF);
        chk("xor_ac", {24'd0, ac}, 32'hC0);
        issue(5'd10, 8'h00, 8'h00);
        chk("not_ac", {24'd0, ac}, 32'h3F);
        issue(5'd2, 8'h00, 8'hA5);
        chk("ldm_ac", {24'd0, ac}, 32'hA5);
        chk("ldm_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0100);

        // MUL 12*11 = 132, mdr toggled while busy
        issue(5'd1, 8'h0C, 8'h00);
        run_op(5'd13, 8'h00, 8'h0B, 1'b1, -1, lat, bcnt);
        chk("mul1_lat", lat, 9);
        chk("mul1_busy", bcnt, 8);
        chk("mul1_ac", {24'd0, ac}, 32'h84);
        chk("mul1_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0100);

        // MUL 0x20*0x10 = 0x200 with a stray start mid-busy
        issue(5'd1, 8'h20, 8'h00);
        run_op(5'd13, 8'h00, 8'h10, 1'b0, 3, lat, bcnt);
        chk("mul2_lat", lat, 9);
        chk("mul2_ac", {24'd0, ac}, 32'h00);
        chk("mul2_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b1010);
        step();
        chk("mul2_nodone", {30'd0, busy, done}, 32'b00);
        chk("mul2_ac_after", {24'd0, ac}, 32'h00);

        // Shifts
        issue(5'd1, 8'h81, 8'h00);
        run_op(5'd11, 8'h01, 8'h00, 1'b0, -1, lat, bcnt);
        chk("shl_lat", lat, 2);
        chk("shl_ac", {24'd0, ac}, 32'h02);
        chk("shl_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0010);
        issue(5'd1, 8'h90, 8'h00);
        run_op(5'd12, 8'h03, 8'h00, 1'b0, -1, lat, bcnt);
        chk("sar_lat", lat, 4);
        chk("sar_busy", bcnt, 3);
        chk("sar_ac", {24'd0, ac}, 32'hF2);
        chk("sar_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0100);
        issue(5'd1, 8'h81, 8'h00);
        run_op(5'd11, 8'h01, 8'h00, 1'b0, -1, lat, bcnt);
        run_op(5'd11, 8'h00, 8'h00, 1'b0, -1, lat, bcnt);
        chk("shl0_lat", lat, 1);
        chk("shl0_ac", {24'd0, ac}, 32'h02);
        chk("shl0_zncv", {28'd0, zflg, nflg, cflg, vflg}, 32'b0000);

        // Reset during RUN cycle 4 of a MUL aborts it
        issue(5'd1, 8'h0C, 8'h00);
        issue(5'd13, 8'h00, 8'h0B);
        chk("mulrst_busy", {31'd0, busy}, 32'd1);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mulrst_ac", {24'd0, ac}, 32'h00);
        chk("mulrst_flags", {28'd0, zflg, nflg, cflg, vflg}, 32'h0);
        chk("mulrst_bd", {30'd0, busy, done}, 32'b00);
        step();
        chk("mulrst_nodone", {30'd0, busy, done}, 32'b00);

        // Illegal opcode holds AC and flags, still pulses done once
        issue(5'd1, 8'h33, 8'h00);
        issue(5'd20, 8'hAA, 8'h55);
        chk("ill_ac", {24'd0, ac}, 32'h33);
        chk("ill_flags", {28'd0, zflg, nflg, cflg, vflg}, 32'b0000);
        chk("ill_done", {30'd0, busy, done}, 32'b01);
        step();
        chk("ill_done_drop", {30'd0, busy, done}, 32'b00);
        chk("no_busy_done_overlap", {31'd0, overlap}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
